// File: rtl/br_redirect_ctrl.sv
// br_redirect_ctrl: tracks a branch handed from IF to ID, marks its delay
// slot, stalls fetch while the branch is unresolved after its delay slot,
// and raises a single redirect request carrying the taken target.
module br_redirect_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fs_fire,
    input  logic        fs_is_branch,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic        redirect_ack,
    output logic        fs_is_ds,
    output logic        fs_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BR_SEEN,
        S_DS_SEEN,
        S_HOLD_TGT,
        S_NT_DS,
        S_REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;

    logic br_tk;
    logic br_nt;

    assign br_tk = br_valid & br_taken;
    assign br_nt = br_valid & ~br_taken;

    // State and target registers; reset clears both.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next-state and target capture; flush overrides every other input.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fs_fire && fs_is_branch) state_d = S_BR_SEEN;
                end
                S_BR_SEEN: begin
                    if (br_tk) begin
                        target_d = br_target;
                        state_d  = fs_fire ? S_REDIRECT : S_HOLD_TGT;
                    end else if (br_nt) begin
                        state_d  = fs_fire ? S_IDLE : S_NT_DS;
                    end else if (fs_fire) begin
                        state_d  = S_DS_SEEN;
                    end
                end
                S_DS_SEEN: begin
                    if (br_tk) begin
                        target_d = br_target;
                        state_d  = S_REDIRECT;
                    end else if (br_nt) begin
                        state_d  = S_IDLE;
                    end
                end
                S_HOLD_TGT: begin
                    if (fs_fire) state_d = S_REDIRECT;
                end
                S_NT_DS: begin
                    if (fs_fire) state_d = S_IDLE;
                end
                S_REDIRECT: begin
                    if (redirect_ack) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from registered state (fs_is_ds also depends on fs_fire).
    always_comb begin
        fs_is_ds       = 1'b0;
        fs_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = target_q;
        if (state_q == S_BR_SEEN || state_q == S_HOLD_TGT || state_q == S_NT_DS)
            fs_is_ds = fs_fire;
        if (state_q == S_DS_SEEN || state_q == S_REDIRECT)
            fs_stall = 1'b1;
        if (state_q == S_REDIRECT)
            redirect_valid = 1'b1;
    end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Self-checking bench for br_redirect_ctrl: directed scenarios plus a
// randomized run compared against a flag-based behavioural model.
module tb_br_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn, fs_fire, fs_is_branch, br_valid, br_taken, flush, redirect_ack;
    logic [31:0] br_target;
    logic        fs_is_ds, fs_stall, redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Model: a branch is "active" until both its delay slot and its
    // resolution have been seen; a taken result then leaves a pending redirect.
    bit          m_active, m_ds, m_res, m_taken, m_redir;
    logic [31:0] m_tgt;

    br_redirect_ctrl dut (
        .clk(clk), .resetn(resetn), .fs_fire(fs_fire), .fs_is_branch(fs_is_branch),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .flush(flush), .redirect_ack(redirect_ack), .fs_is_ds(fs_is_ds),
        .fs_stall(fs_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic bit exp_stall();
        return m_redir || (m_active && m_ds && !m_res);
    endfunction

    function automatic bit exp_is_ds();
        return fs_fire && m_active && !m_ds;
    endfunction

    task automatic model_step();
        if (!resetn) begin
            m_active = 0; m_ds = 0; m_res = 0; m_taken = 0; m_redir = 0; m_tgt = '0;
        end else if (flush) begin
            m_active = 0; m_ds = 0; m_res = 0; m_taken = 0; m_redir = 0;
        end else if (m_redir) begin
            if (redirect_ack) m_redir = 0;
        end else if (m_active) begin
            if (fs_fire && !m_ds) m_ds = 1;
            if (br_valid && !m_res) begin
                m_res = 1; m_taken = br_taken;
                if (br_taken) m_tgt = br_target;
            end
            if (m_ds && m_res) begin
                m_redir = m_taken; m_active = 0; m_ds = 0; m_res = 0;
            end
        end else if (fs_fire && fs_is_branch) begin
            m_active = 1; m_ds = 0; m_res = 0;
        end
    endtask

    task automatic set(input bit fire, input bit isbr, input bit bv, input bit bt,
                       input logic [31:0] tgt, input bit fl, input bit ack, input bit rn);
        fs_fire = fire; fs_is_branch = isbr; br_valid = bv; br_taken = bt;
        br_target = tgt; flush = fl; redirect_ack = ack; resetn = rn;
        #1;
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 32'h0, 0, 0, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        set(0, 0, 0, 0, 32'h0, 0, 0, 0);
        tick();
        idle();
        total++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv got %b want 0", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", redirect_pc); else passed++;
        total++; if (fs_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", fs_stall); else passed++;
        total++; if (fs_is_ds !== 1'b0) $display("FAIL reset_is_ds got %b want 0", fs_is_ds); else passed++;
    endtask

    task automatic test_taken_after_ds();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b0) $display("FAIL tad_br_is_ds got %b want 0", fs_is_ds); else passed++;
        tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b1) $display("FAIL tad_ds_is_ds got %b want 1", fs_is_ds); else passed++;
        tick();
        set(0, 0, 1, 1, 32'hBFC0_0100, 0, 0, 1);
        total++; if (fs_stall !== 1'b1) $display("FAIL tad_stall got %b want 1", fs_stall); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL tad_rv_early got %b want 0", redirect_valid); else passed++;
        tick();
        idle();
        total++; if (redirect_valid !== 1'b1) $display("FAIL tad_rv got %b want 1", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'hBFC0_0100) $display("FAIL tad_pc got %h want bfc00100", redirect_pc); else passed++;
        tick();
        set(0, 0, 0, 0, 32'h0, 0, 1, 1);
        total++; if (redirect_valid !== 1'b1) $display("FAIL tad_rv_held got %b want 1", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'hBFC0_0100) $display("FAIL tad_pc_held got %h want bfc00100", redirect_pc); else passed++;
        tick();
        idle();
        total++; if (redirect_valid !== 1'b0) $display("FAIL tad_rv_after_ack got %b want 0", redirect_valid); else passed++;
        total++; if (fs_stall !== 1'b0) $display("FAIL tad_stall_after_ack got %b want 0", fs_stall); else passed++;
    endtask

    task automatic test_taken_before_ds();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1);
        tick();
        set(0, 0, 1, 1, 32'h8000_0040, 0, 0, 1);
        tick();
        idle();
        total++; if (fs_stall !== 1'b0) $display("FAIL tbd_stall got %b want 0", fs_stall); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL tbd_rv_hold got %b want 0", redirect_valid); else passed++;
        tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b1) $display("FAIL tbd_is_ds got %b want 1", fs_is_ds); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL tbd_rv_ds got %b want 0", redirect_valid); else passed++;
        tick();
        set(0, 0, 0, 0, 32'h0, 0, 1, 1);
        total++; if (redirect_valid !== 1'b1) $display("FAIL tbd_rv got %b want 1", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h8000_0040) $display("FAIL tbd_pc got %h want 80000040", redirect_pc); else passed++;
        tick();
        idle();
        total++; if (redirect_valid !== 1'b0) $display("FAIL tbd_rv_after_ack got %b want 0", redirect_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1);
        tick();
        set(1, 0, 1, 0, 32'h1234_5678, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b1) $display("FAIL b2b_is_ds got %b want 1", fs_is_ds); else passed++;
        tick();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_stall !== 1'b0) $display("FAIL b2b_stall got %b want 0", fs_stall); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL b2b_rv got %b want 0", redirect_valid); else passed++;
        total++; if (fs_is_ds !== 1'b0) $display("FAIL b2b_br_is_ds got %b want 0", fs_is_ds); else passed++;
        tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b1) $display("FAIL b2b_second_ds got %b want 1", fs_is_ds); else passed++;
        tick();
        set(0, 0, 1, 0, 32'h0, 0, 0, 1);
        total++; if (fs_stall !== 1'b1) $display("FAIL b2b_stall_ds got %b want 1", fs_stall); else passed++;
        tick();
        idle();
        total++; if (fs_stall !== 1'b0) $display("FAIL b2b_stall_nt got %b want 0", fs_stall); else passed++;
    endtask

    task automatic test_nt_ds_branch();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1);
        tick();
        set(0, 0, 1, 0, 32'h0, 0, 0, 1);
        tick();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b1) $display("FAIL ntd_is_ds got %b want 1", fs_is_ds); else passed++;
        tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1);
        total++; if (fs_is_ds !== 1'b0) $display("FAIL ntd_ignored_br got %b want 0", fs_is_ds); else passed++;
        total++; if (fs_stall !== 1'b0) $display("FAIL ntd_stall got %b want 0", fs_stall); else passed++;
        tick();
    endtask

    task automatic test_flush();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1); tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1); tick();
        set(0, 0, 1, 1, 32'hCAFE_0004, 0, 0, 1); tick();
        set(0, 0, 0, 0, 32'h0, 1, 1, 1);
        total++; if (redirect_valid !== 1'b1) $display("FAIL fl_rv_pre got %b want 1", redirect_valid); else passed++;
        tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1);
        total++; if (redirect_valid !== 1'b0) $display("FAIL fl_rv got %b want 0", redirect_valid); else passed++;
        total++; if (fs_stall !== 1'b0) $display("FAIL fl_stall got %b want 0", fs_stall); else passed++;
        total++; if (fs_is_ds !== 1'b0) $display("FAIL fl_is_ds got %b want 0", fs_is_ds); else passed++;
        tick();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1); tick();
        set(1, 0, 0, 0, 32'h0, 0, 0, 1); tick();
        set(0, 0, 1, 1, 32'h0BAD_0000, 1, 0, 1);
        total++; if (fs_stall !== 1'b1) $display("FAIL fl_ds_stall_pre got %b want 1", fs_stall); else passed++;
        tick();
        idle();
        total++; if (fs_stall !== 1'b0) $display("FAIL fl_ds_stall got %b want 0", fs_stall); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL fl_ds_rv got %b want 0", redirect_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        set(1, 1, 0, 0, 32'h0, 0, 0, 1); tick();
        set(1, 0, 1, 1, 32'hDEAD_BEE0, 0, 0, 1); tick();
        set(0, 0, 0, 0, 32'h0, 0, 0, 0);
        total++; if (redirect_valid !== 1'b1) $display("FAIL rm_rv_pre got %b want 1", redirect_valid); else passed++;
        tick();
        idle();
        total++; if (redirect_valid !== 1'b0) $display("FAIL rm_rv got %b want 0", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL rm_pc got %h want 0", redirect_pc); else passed++;
        total++; if (fs_stall !== 1'b0) $display("FAIL rm_stall got %b want 0", fs_stall); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            set($urandom_range(1, 0) == 1, $urandom_range(4, 0) < 2,
                $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, $urandom,
                $urandom_range(19, 0) == 0, $urandom_range(1, 0) == 1,
                $urandom_range(49, 0) != 0);
            total++; if (fs_is_ds !== exp_is_ds()) $display("FAIL rnd_is_ds cyc %0d got %b want %b", i, fs_is_ds, exp_is_ds()); else passed++;
            total++; if (fs_stall !== exp_stall()) $display("FAIL rnd_stall cyc %0d got %b want %b", i, fs_stall, exp_stall()); else passed++;
            total++; if (redirect_valid !== m_redir) $display("FAIL rnd_rv cyc %0d got %b want %b", i, redirect_valid, m_redir); else passed++;
            total++; if (redirect_pc !== m_tgt) $display("FAIL rnd_pc cyc %0d got %h want %h", i, redirect_pc, m_tgt); else passed++;
            tick();
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_taken_after_ds();
        test_taken_before_ds();
        test_back_to_back();
        test_nt_ds_branch();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
